score_level_tracker: RTL

Parametrised score/level unit for the game datapath; replaces the fixed 32-bit binary score counter. Accepts multi-point score events on a single clock, keeps a DIGITS-wide BCD score for direct 7-seg display, derives a level every LEVEL_STEP points and holds a high-score register across games. Sits between the collision/event logic and the display/speed-control blocks.

---
 rtl/score_level_tracker_if.sv | 69 ++++++
 rtl/score_level_tracker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/score_level_tracker_if.sv
// ---------------------------------------------------------------------------
// score_level_tracker_if
//
// Bundle of the event inputs and display/status outputs of the score/level
// tracker. Clock and reset are not part of the bundle; they stay plain ports
// on the tracker itself.
//
// Signals:
//   clr        new-game clear (high score kept)
//   gameover   level, high while the game is frozen
//   hit        score event strobe, counted once per rising edge
//   points     point value of the event, sampled on the hit rising edge
//   score_bcd  current score, DIGITS BCD digits, digit 0 in [3:0]
//   high_bcd   best score so far, same format as score_bcd
//   level      current level
//   levelup    one-cycle pulse per level increment
//   new_high   one-cycle pulse when high_bcd is updated
//   saturated  score stuck at all nines until clr/rst
//   busy       pending points not yet added to the score
//
// Modports:
//   master  event source / display consumer side
//   slave   tracker side
// ---------------------------------------------------------------------------
interface score_level_tracker_if #(
    parameter int DIGITS = 4,
    parameter int PTS_W  = 4,
    parameter int LVL_W  = 4
);
    logic                  clr;
    logic                  gameover;
    logic                  hit;
    logic [PTS_W-1:0]      points;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [4*DIGITS-1:0]   high_bcd;
    logic [LVL_W-1:0]      level;
    logic                  levelup;
    logic                  new_high;
    logic                  saturated;
    logic                  busy;

    modport master (
        output clr,
        output gameover,
        output hit,
        output points,
        input  score_bcd,
        input  high_bcd,
        input  level,
        input  levelup,
        input  new_high,
        input  saturated,
        input  busy
    );

    modport slave (
        input  clr,
        input  gameover,
        input  hit,
        input  points,
        output score_bcd,
        output high_bcd,
        output level,
        output levelup,
        output new_high,
        output saturated,
        output busy
    );
endinterface

// File: rtl/score_level_tracker.sv
// ---------------------------------------------------------------------------
// score_level_tracker
//
// Score/level unit for the game datapath. Multi-point score events are
// accumulated into a pending counter which drains one point per cycle into a
// DIGITS-wide BCD score, so the score can drive 7-segment displays directly.
// Every LEVEL_STEP drained points advance the level (clamped at MAX_LEVEL).
// When the game freezes (gameover rising) the score is compared against the
// high-score register, which survives new-game clears.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset, clears everything incl. high score
//   bus   score_level_tracker_if.slave:
//           in : clr, gameover, hit, points
//           out: score_bcd, high_bcd, level, levelup, new_high, saturated,
//                busy
//
// Priority per cycle: rst > clr > gameover > normal counting.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module score_level_tracker #(
    parameter int DIGITS     = 4,
    parameter int PTS_W      = 4,
    parameter int PEND_W     = 8,
    parameter int LEVEL_STEP = 8,
    parameter int MAX_LEVEL  = 15,
    parameter int LVL_W      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    score_level_tracker_if.slave   bus
);

    localparam int SCORE_W = 4 * DIGITS;
    localparam int STEP_W  = $clog2(LEVEL_STEP);
    // One spare bit so the add can be checked for overflow before clamping.
    localparam int SUM_W   = ((PEND_W > PTS_W) ? PEND_W : PTS_W) + 1;

    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LEVEL_STEP - 1);
    localparam logic [LVL_W-1:0]  LEVEL_TOP = LVL_W'(MAX_LEVEL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SCORE_W-1:0] score_reg;
    logic [SCORE_W-1:0] high_reg;
    logic [LVL_W-1:0]   level_reg;
    logic [STEP_W-1:0]  step_reg;
    logic [PEND_W-1:0]  pending_reg;
    logic               hit_q_reg;
    logic               go_q_reg;
    logic               levelup_reg;
    logic               new_high_reg;
    logic               saturated_reg;
    logic               busy_reg;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic hit_rise;
    logic go_rise;

    assign hit_rise = bus.hit & ~hit_q_reg;
    assign go_rise  = bus.gameover & ~go_q_reg;

    // ------------------------------------------------------------------
    // BCD +1: ripple carry across digits, resolved in one cycle.
    // carry[DIGITS] set means every digit was 9, i.e. the score is full.
    // ------------------------------------------------------------------
    logic [DIGITS:0]    carry;
    logic [SCORE_W-1:0] score_inc;
    logic               all_nines;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_bcd_digit
            logic [3:0] digit;
            logic       is_nine;

            assign digit   = score_reg[4*gi +: 4];
            assign is_nine = (digit == 4'd9);

            assign score_inc[4*gi +: 4] = carry[gi] ? (is_nine ? 4'd0 : digit + 4'd1)
                                                    : digit;
            assign carry[gi+1]          = carry[gi] & is_nine;
        end
    endgenerate

    assign all_nines = carry[DIGITS];

    // ------------------------------------------------------------------
    // Pending accumulator: one point drains per cycle while non-zero, the
    // new event (if any) is added in the same cycle, result clamps at max.
    // ------------------------------------------------------------------
    logic              drain;
    logic              add_en;
    logic [SUM_W-1:0]  pending_sum;
    logic [PEND_W-1:0] pending_next;

    assign drain  = (pending_reg != '0);
    // Once saturated the score can never move again, so new events are
    // dropped instead of filling the accumulator.
    assign add_en = hit_rise & ~saturated_reg;

    always_comb begin
        pending_sum = SUM_W'(pending_reg) - SUM_W'(drain)
                    + (add_en ? SUM_W'(bus.points) : SUM_W'(0));
        if (pending_sum > SUM_W'(PEND_MAX)) begin
            pending_next = PEND_MAX;
        end else begin
            pending_next = pending_sum[PEND_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Level stepping
    // ------------------------------------------------------------------
    logic step_wrap;
    logic level_can_rise;

    assign step_wrap      = (step_reg == STEP_LAST);
    assign level_can_rise = (level_reg < LEVEL_TOP);

    // ------------------------------------------------------------------
    // High score compare. Packed BCD digits with the most significant
    // digit in the top nibble order exactly like the decimal values, so a
    // plain unsigned compare is the digit-wise magnitude compare.
    // ------------------------------------------------------------------
    logic score_beats_high;

    assign score_beats_high = (score_reg > high_reg);

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            score_reg     <= '0;
            high_reg      <= '0;
            level_reg     <= '0;
            step_reg      <= '0;
            pending_reg   <= '0;
            hit_q_reg     <= 1'b0;
            go_q_reg      <= 1'b0;
            levelup_reg   <= 1'b0;
            new_high_reg  <= 1'b0;
            saturated_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (bus.clr) begin
            // New game: high score survives, and go_q holds its value so a
            // clear issued while frozen does not produce a fresh go_rise.
            score_reg     <= '0;
            level_reg     <= '0;
            step_reg      <= '0;
            pending_reg   <= '0;
            hit_q_reg     <= 1'b0;
            levelup_reg   <= 1'b0;
            new_high_reg  <= 1'b0;
            saturated_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            hit_q_reg    <= bus.hit;
            go_q_reg     <= bus.gameover;
            levelup_reg  <= 1'b0;
            new_high_reg <= 1'b0;

            if (bus.gameover) begin
                // Frozen: score/level/step/pending held, events ignored.
                if (go_rise) begin
                    pending_reg <= '0;
                    busy_reg    <= 1'b0;
                    if (score_beats_high) begin
                        high_reg     <= score_reg;
                        new_high_reg <= 1'b1;
                    end
                end
            end else if (drain && all_nines) begin
                // Score cannot grow further: discard whatever is left.
                saturated_reg <= 1'b1;
                pending_reg   <= '0;
                busy_reg      <= 1'b0;
            end else begin
                pending_reg <= pending_next;
                busy_reg    <= (pending_next != '0);

                if (drain) begin
                    score_reg <= score_inc;
                    if (step_wrap) begin
                        step_reg <= '0;
                        if (level_can_rise) begin
                            level_reg   <= level_reg + LVL_W'(1);
                            levelup_reg <= 1'b1;
                        end
                    end else begin
                        step_reg <= step_reg + STEP_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.score_bcd = score_reg;
    assign bus.high_bcd  = high_reg;
    assign bus.level     = level_reg;
    assign bus.levelup   = levelup_reg;
    assign bus.new_high  = new_high_reg;
    assign bus.saturated = saturated_reg;
    assign bus.busy      = busy_reg;

endmodule
